ex_branch_rs: RTL
=================

Name: ex_branch_rs

Overview:
- Branch execution unit with a DEPTH-entry in-order reservation queue. It replaces the single-slot branch executor.
- Accepts conditional branches and JALR from dispatch and captures operands from the CDB when they are broadcast.
- Resolves the oldest ready entry and sends a redirect to IF. For JALR it also drives a link writeback to the CDB arbiter.

Parameters:
- XLEN, 32, data/address width
- DEPTH, 4, queue entries; power of two, ≥2
- TAG_W, 5, register tag width
- TAG_UNLOCKED, 0, tag value meaning "operand data valid"

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  global ready; low freezes all state and outputs
- flush_in  in  1  discard all queued entries
- disp_valid_in  in  1  dispatch request
- disp_op_in  in  3  1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JALR; 0 is illegal
- disp_pc_in  in  XLEN  instruction PC
- disp_offset_in  in  XLEN  sign-extended immediate
- disp_tagx_in, disp_tagy_in  in  TAG_W  operand tags
- disp_datax_in, disp_datay_in  in  XLEN  operand data, valid when tag==TAG_UNLOCKED
- disp_rd_tag_in  in  TAG_W  link destination tag (JALR)
- cdb_valid_in  in  1  CDB broadcast valid
- cdb_tag_in  in  TAG_W  broadcast tag
- cdb_data_in  in  XLEN  broadcast value
- full_out  out  1  queue full, to allocator
- en  out  1  redirect valid, one-cycle pulse
- dest_out  out  XLEN  next PC
- link_valid_out  out  1  link writeback valid, one-cycle pulse
- link_tag_out  out  TAG_W  link destination tag
- link_data_out  out  XLEN  pc+4

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, head/tail/count=0.
  - Outputs after reset: en=0, dest_out=0, link_valid_out=0, link_tag_out=0, link_data_out=0, full_out=0.
  - Reset takes priority over rdy and flush.
- rdy=0: no state update; all registered outputs hold their values.
- full_out = (count==DEPTH), combinational from registered count.
- Dispatch: accepted when disp_valid_in && !full_out && !flush_in && disp_op_in!=0.
  - Entry is written at tail; tail wraps mod DEPTH.
  - disp_op_in=0 is dropped silently.
  - Dispatch while full is ignored; the allocator must not do it.
- Same-cycle capture: if cdb_valid_in and cdb_tag_in equals a nonzero incoming operand tag, that operand is stored with the CDB data and tag TAG_UNLOCKED.
- Wakeup: each cycle, every valid entry operand whose tag matches a valid CDB tag latches the data and becomes TAG_UNLOCKED. A CDB tag equal to TAG_UNLOCKED never matches.
- Issue is in order: only the head entry issues, and only when both of its tags are TAG_UNLOCKED at the start of the cycle. Wakeups take effect from the next cycle.
  - At most one issue per cycle.
  - head advances and count decrements on issue.
  - Dispatch and issue in the same cycle leave count unchanged.
- Resolution, registered; outputs are visible the cycle after issue:
  - jump = pc+offset; remain = pc+4; all arithmetic mod 2^XLEN.
  - BEQ/BNE use ==/!=. BLT/BGE are signed. BLTU/BGEU are unsigned.
  - dest_out = condition ? jump : remain.
  - JALR: dest_out = (x+offset) & ~1; link_valid_out=1, link_tag_out=rd tag, link_data_out=pc+4.
  - When en=0, dest_out=0. When link_valid_out=0, link_tag_out=0 and link_data_out=0.
- Flush (flush_in=1, rdy=1): next cycle the queue is empty and en=0, link_valid_out=0.
  - An issue in the flush cycle is suppressed.
  - A dispatch in the flush cycle is ignored.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: BRANCH_PREDICT_EN.
- Defined:
  - Adds input disp_pred_in [XLEN], the predicted next PC, stored per entry.
  - en=1 only when the computed destination differs from the stored prediction; dest_out holds the correct PC.
  - Adds output mispredict_cnt_out [32], incremented on each en pulse, reset to 0, saturates at all-ones.
- Undefined: every resolved entry pulses en, and disp_pred_in and mispredict_cnt_out do not exist.

Test Plan:
- Reset then idle -> en=0, dest_out=0, full_out=0, link_valid_out=0 for 10 cycles.
- Dispatch BLT pc=0x100, off=0x20, x=0xFFFFFFFF, y=1, tags unlocked -> 2 cycles after dispatch: en=1, dest_out=0x120. Repeat as BLTU -> dest_out=0x104.
- Dispatch BEQ with tagx=3 pending, then a younger ready BNE -> neither issues. CDB tag 3 data=5 (y=5) -> BEQ resolves dest=jump, BNE resolves on the following cycle.
- JALR pc=0x200, x=0x1001, off=4, rd tag=7 -> en=1, dest_out=0x1004, link_valid_out=1, link_tag_out=7, link_data_out=0x204.
- Fill DEPTH=4 entries all blocked -> full_out=1 and a 5th dispatch is ignored. flush_in -> next cycle full_out=0, and no en pulse occurs for the flushed entries.
- Hold rdy=0 during a pending issue -> outputs and queue frozen. Raise rdy -> the issue proceeds with the same result.

Source files
------------

// File: rtl/ex_branch_rs.sv
// Branch execution unit: DEPTH-entry in-order reservation queue with CDB wakeup,
// registered redirect and JALR link writeback. Optional macro BRANCH_PREDICT_EN.
module ex_branch_rs #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int TAG_W        = 5,
   parameter int TAG_UNLOCKED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             flush_in,
   input  logic             disp_valid_in,
   input  logic [2:0]       disp_op_in,
   input  logic [XLEN-1:0]  disp_pc_in,
   input  logic [XLEN-1:0]  disp_offset_in,
   input  logic [TAG_W-1:0] disp_tagx_in,
   input  logic [TAG_W-1:0] disp_tagy_in,
   input  logic [XLEN-1:0]  disp_datax_in,
   input  logic [XLEN-1:0]  disp_datay_in,
   input  logic [TAG_W-1:0] disp_rd_tag_in,
`ifdef BRANCH_PREDICT_EN
   input  logic [XLEN-1:0]  disp_pred_in,
   output logic [31:0]      mispredict_cnt_out,
`endif
   input  logic             cdb_valid_in,
   input  logic [TAG_W-1:0] cdb_tag_in,
   input  logic [XLEN-1:0]  cdb_data_in,
   output logic             full_out,
   output logic             en,
   output logic [XLEN-1:0]  dest_out,
   output logic             link_valid_out,
   output logic [TAG_W-1:0] link_tag_out,
   output logic [XLEN-1:0]  link_data_out
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [TAG_W-1:0] UNL = TAG_W'(TAG_UNLOCKED);
   localparam logic [2:0] OP_BEQ  = 3'd1;
   localparam logic [2:0] OP_BNE  = 3'd2;
   localparam logic [2:0] OP_BLT  = 3'd3;
   localparam logic [2:0] OP_BGE  = 3'd4;
   localparam logic [2:0] OP_BLTU = 3'd5;
   localparam logic [2:0] OP_BGEU = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   logic [2:0]       q_op    [DEPTH];
   logic [XLEN-1:0]  q_pc    [DEPTH];
   logic [XLEN-1:0]  q_off   [DEPTH];
   logic [TAG_W-1:0] q_tagx  [DEPTH];
   logic [TAG_W-1:0] q_tagy  [DEPTH];
   logic [XLEN-1:0]  q_datax [DEPTH];
   logic [XLEN-1:0]  q_datay [DEPTH];
   logic [TAG_W-1:0] q_rd    [DEPTH];
`ifdef BRANCH_PREDICT_EN
   logic [XLEN-1:0]  q_pred  [DEPTH];
   logic             mispred;
`endif

   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic          disp_acc, issue, cdb_hit, take;
   logic [XLEN-1:0] hx, hy, h_jump, h_remain, res_dest;

   assign full_out = (count == (PW+1)'(DEPTH));
   assign disp_acc = disp_valid_in && !full_out && !flush_in && (disp_op_in != 3'd0);
   assign cdb_hit  = cdb_valid_in && (cdb_tag_in != UNL);
   // Readiness uses registered tags only, so a wakeup becomes issuable next cycle.
   assign issue    = (count != '0) && !flush_in &&
                     (q_tagx[head] == UNL) && (q_tagy[head] == UNL);

   assign hx       = q_datax[head];
   assign hy       = q_datay[head];
   assign h_jump   = q_pc[head] + q_off[head];
   assign h_remain = q_pc[head] + XLEN'(4);

   always_comb begin
      take = 1'b0;
      case (q_op[head])
         OP_BEQ:  take = (hx == hy);
         OP_BNE:  take = (hx != hy);
         OP_BLT:  take = ($signed(hx) < $signed(hy));
         OP_BGE:  take = ($signed(hx) >= $signed(hy));
         OP_BLTU: take = (hx < hy);
         OP_BGEU: take = (hx >= hy);
         default: take = 1'b0;
      endcase
      if (q_op[head] == OP_JALR) res_dest = (hx + q_off[head]) & ~XLEN'(1);
      else                       res_dest = take ? h_jump : h_remain;
   end

`ifdef BRANCH_PREDICT_EN
   assign mispred = (res_dest != q_pred[head]);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         en             <= 1'b0;
         dest_out       <= '0;
         link_valid_out <= 1'b0;
         link_tag_out   <= '0;
         link_data_out  <= '0;
`ifdef BRANCH_PREDICT_EN
         mispredict_cnt_out <= '0;
`endif
      end else if (rdy) begin
         en             <= 1'b0;
         dest_out       <= '0;
         link_valid_out <= 1'b0;
         link_tag_out   <= '0;
         link_data_out  <= '0;
         if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (cdb_hit) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (q_tagx[i] == cdb_tag_in) begin
                     q_tagx[i]  <= UNL;
                     q_datax[i] <= cdb_data_in;
                  end
                  if (q_tagy[i] == cdb_tag_in) begin
                     q_tagy[i]  <= UNL;
                     q_datay[i] <= cdb_data_in;
                  end
               end
            end
            if (disp_acc) begin
               q_op[tail]  <= disp_op_in;
               q_pc[tail]  <= disp_pc_in;
               q_off[tail] <= disp_offset_in;
               q_rd[tail]  <= disp_rd_tag_in;
`ifdef BRANCH_PREDICT_EN
               q_pred[tail] <= disp_pred_in;
`endif
               if (cdb_hit && disp_tagx_in == cdb_tag_in) begin
                  q_tagx[tail]  <= UNL;
                  q_datax[tail] <= cdb_data_in;
               end else begin
                  q_tagx[tail]  <= disp_tagx_in;
                  q_datax[tail] <= disp_datax_in;
               end
               if (cdb_hit && disp_tagy_in == cdb_tag_in) begin
                  q_tagy[tail]  <= UNL;
                  q_datay[tail] <= cdb_data_in;
               end else begin
                  q_tagy[tail]  <= disp_tagy_in;
                  q_datay[tail] <= disp_datay_in;
               end
               tail <= tail + 1'b1;
            end
            if (issue) begin
               head <= head + 1'b1;
`ifdef BRANCH_PREDICT_EN
               en       <= mispred;
               dest_out <= mispred ? res_dest : '0;
               if (mispred && mispredict_cnt_out != '1)
                  mispredict_cnt_out <= mispredict_cnt_out + 32'd1;
`else
               en       <= 1'b1;
               dest_out <= res_dest;
`endif
               if (q_op[head] == OP_JALR) begin
                  link_valid_out <= 1'b1;
                  link_tag_out   <= q_rd[head];
                  link_data_out  <= h_remain;
               end
            end
            if (disp_acc && !issue)      count <= count + 1'b1;
            else if (!disp_acc && issue) count <= count - 1'b1;
         end
      end
   end

endmodule
